// File: rtl/multicycle_alu_if.sv
// Handshake and data bundle between a requester and the multicycle ALU.
// The requester drives start/opc/a/b; the ALU returns results and status.
interface multicycle_alu_if #(
    parameter int unsigned N = 32
);
    logic         start;
    logic [2:0]   opc;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] w;
    logic [N-1:0] hi;
    logic         zero;
    logic         neg;
    logic         busy;
    logic         done;

    modport master (
        output start, opc, a, b,
        input  w, hi, zero, neg, busy, done
    );

    modport slave (
        input  start, opc, a, b,
        output w, hi, zero, neg, busy, done
    );
endinterface

// File: rtl/multicycle_alu.sv
// ALU with single-cycle logic/arith ops plus iterative shift-add MULU and
// restoring DIVU, one bit per cycle; results stay held until the next done.
module multicycle_alu #(
    parameter int unsigned N = 32
) (
    input logic              clk,
    input logic              rst,
    multicycle_alu_if.slave  bus
);
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [N-1:0]  r_acc, w_acc_nxt;
    logic [N-1:0]  r_q, w_q_nxt;
    logic [N-1:0]  r_m, w_m_nxt;
    logic [N-1:0]  r_w, w_w_nxt;
    logic [N-1:0]  r_hi, w_hi_nxt;
    logic          r_done, w_done_nxt;

    logic [N:0]    w_mul_sum;
    logic [N:0]    w_div_shift;
    logic [N:0]    w_div_diff;
    logic          w_div_bit;
    logic [N-1:0]  w_div_rem;
    logic          w_last;

    // r_acc is the high product half / partial remainder; r_q holds multiplier
    // bits shifting out and product/quotient bits shifting in.
    assign w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
    assign w_div_shift = {r_acc, r_q[N-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_m};
    assign w_div_bit   = ~w_div_diff[N];
    assign w_div_rem   = w_div_bit ? w_div_diff[N-1:0] : w_div_shift[N-1:0];
    assign w_last      = (r_cnt == CW'(N - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_q_nxt     = r_q;
        w_m_nxt     = r_m;
        w_w_nxt     = r_w;
        w_hi_nxt    = r_hi;
        w_done_nxt  = 1'b0;
        case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_hi_nxt   = '0;
                    w_done_nxt = 1'b1;
                    unique case (bus.opc)
                        3'b000: w_w_nxt = bus.a + bus.b;
                        3'b001: w_w_nxt = bus.a - bus.b;
                        3'b010: w_w_nxt = bus.a & bus.b;
                        3'b011: w_w_nxt = bus.a | bus.b;
                        3'b100: w_w_nxt = {{(N-1){1'b0}}, (bus.a < bus.b)};
                        3'b101: w_w_nxt = bus.a ^ bus.b;
                        3'b110: begin
                            w_hi_nxt    = r_hi;
                            w_done_nxt  = 1'b0;
                            w_state_nxt = StMul;
                            w_acc_nxt   = '0;
                            w_q_nxt     = bus.a;
                            w_m_nxt     = bus.b;
                            w_cnt_nxt   = '0;
                        end
                        3'b111: begin
                            if (bus.b == '0) begin
                                w_w_nxt  = '1;
                                w_hi_nxt = bus.a;
                            end else begin
                                w_hi_nxt    = r_hi;
                                w_done_nxt  = 1'b0;
                                w_state_nxt = StDiv;
                                w_acc_nxt   = '0;
                                w_q_nxt     = bus.a;
                                w_m_nxt     = bus.b;
                                w_cnt_nxt   = '0;
                            end
                        end
                    endcase
                end
            end
            StMul: begin
                w_acc_nxt = w_mul_sum[N:1];
                w_q_nxt   = {w_mul_sum[0], r_q[N-1:1]};
                w_cnt_nxt = r_cnt + CW'(1);
                if (w_last) begin
                    w_w_nxt     = {w_mul_sum[0], r_q[N-1:1]};
                    w_hi_nxt    = w_mul_sum[N:1];
                    w_done_nxt  = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            StDiv: begin
                w_acc_nxt = w_div_rem;
                w_q_nxt   = {r_q[N-2:0], w_div_bit};
                w_cnt_nxt = r_cnt + CW'(1);
                if (w_last) begin
                    w_w_nxt     = {r_q[N-2:0], w_div_bit};
                    w_hi_nxt    = w_div_rem;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_w     <= '0;
            r_hi    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
            r_q     <= w_q_nxt;
            r_m     <= w_m_nxt;
            r_w     <= w_w_nxt;
            r_hi    <= w_hi_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.w    = r_w;
    assign bus.hi   = r_hi;
    assign bus.zero = (r_w == '0);
    assign bus.neg  = r_w[N-1];
    assign bus.busy = (r_state != StIdle);
    assign bus.done = r_done;
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu (N=32): expected results are queued at
// issue time from a 64-bit reference model and popped on each done pulse.
module tb_multicycle_alu;
    localparam int unsigned N = 32;

    typedef struct {
        logic [31:0] w;
        logic [31:0] hi;
        int          busy_n;
        string       tag;
    } exp_t;

    logic clk;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;
    exp_t exp_q[$];

    multicycle_alu_if #(.N(N)) bus ();

    multicycle_alu #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] x,
                                   input logic [31:0] y, input string tag);
        exp_t        e;
        logic [63:0] p;
        e.tag    = tag;
        e.hi     = '0;
        e.busy_n = 0;
        case (op)
            3'd0: e.w = x + y;
            3'd1: e.w = x - y;
            3'd2: e.w = x & y;
            3'd3: e.w = x | y;
            3'd4: e.w = (x < y) ? 32'd1 : 32'd0;
            3'd5: e.w = x ^ y;
            3'd6: begin
                p        = {32'd0, x} * {32'd0, y};
                e.w      = p[31:0];
                e.hi     = p[63:32];
                e.busy_n = 32;
            end
            default: begin
                if (y == 0) begin
                    e.w  = 32'hFFFF_FFFF;
                    e.hi = x;
                end else begin
                    e.w      = x / y;
                    e.hi     = x % y;
                    e.busy_n = 32;
                end
            end
        endcase
        return e;
    endfunction

    // Drive one request, push its expectation, and return just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         input string tag);
        exp_q.push_back(model(op, x, y, tag));
        bus.start = 1'b1;
        bus.opc   = op;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_result(input bit toggle, input bit poke);
        int   busy_n = 0;
        int   cyc    = 0;
        exp_t e;
        while (bus.done !== 1'b1 && cyc < 200) begin
            if (bus.busy === 1'b1) busy_n++;
            if (toggle) begin
                bus.a   = $urandom;
                bus.b   = $urandom;
                bus.opc = 3'($urandom);
            end
            if (poke && bus.busy === 1'b1) begin
                bus.start = 1'b1;
                bus.opc   = 3'd0;
                bus.a     = 32'h1111;
                bus.b     = 32'h2222;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        if (bus.busy === 1'b1) busy_n++;
        if (bus.done !== 1'b1) begin
            check("done_timeout", {63'd0, bus.done}, 64'd1);
        end else if (exp_q.size() == 0) begin
            check("unexpected_done", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({e.tag, ".w"},    {32'd0, bus.w},       {32'd0, e.w});
            check({e.tag, ".hi"},   {32'd0, bus.hi},      {32'd0, e.hi});
            check({e.tag, ".zero"}, {63'd0, bus.zero},    {63'd0, (e.w == 32'd0)});
            check({e.tag, ".neg"},  {63'd0, bus.neg},     {63'd0, e.w[31]});
            check({e.tag, ".busy"}, 64'(busy_n),          64'(e.busy_n));
        end
    endtask

    // Count done/busy activity over a window where nothing should be running.
    task automatic quiet(input string tag, input int cycles);
        int n_done = 0;
        int n_busy = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0) n_done++;
            if (bus.busy !== 1'b0) n_busy++;
        end
        check({tag, ".extra_done"}, 64'(n_done), 64'd0);
        check({tag, ".extra_busy"}, 64'(n_busy), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.opc   = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        @(posedge clk);
        #1;
        check("rst.w",    {32'd0, bus.w},    64'd0);
        check("rst.hi",   {32'd0, bus.hi},   64'd0);
        check("rst.busy", {63'd0, bus.busy}, 64'd0);
        check("rst.done", {63'd0, bus.done}, 64'd0);
        check("rst.zero", {63'd0, bus.zero}, 64'd1);
        check("rst.neg",  {63'd0, bus.neg},  64'd0);
        rst = 1'b0;

        // First start lands on the first edge after reset release.
        issue(3'd0, 32'hFFFF_FFFF, 32'd1, "add_wrap");
        wait_result(1'b0, 1'b0);
        issue(3'd1, 32'd3, 32'd5, "sub_3_5");
        wait_result(1'b0, 1'b0);
        issue(3'd4, 32'd3, 32'd5, "slt_3_5");
        wait_result(1'b0, 1'b0);
        issue(3'd4, 32'd5, 32'd3, "slt_5_3");
        wait_result(1'b0, 1'b0);
        issue(3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, "and");
        wait_result(1'b0, 1'b0);
        issue(3'd3, 32'hF0F0_1234, 32'h0FF0_FF00, "or");
        wait_result(1'b0, 1'b0);
        issue(3'd5, 32'hF0F0_1234, 32'h0FF0_FF00, "xor");
        wait_result(1'b0, 1'b0);

        issue(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max_toggle");
        wait_result(1'b1, 1'b0);
        issue(3'd6, 32'h0001_2345, 32'h0000_6789, "mul_poke");
        wait_result(1'b0, 1'b1);
        quiet("after_poke", 4);

        issue(3'd7, 32'd100, 32'd7, "div_100_7");
        wait_result(1'b0, 1'b0);
        issue(3'd7, 32'd9, 32'd0, "div_by_zero");
        wait_result(1'b0, 1'b0);
        issue(3'd7, 32'hFFFF_FFFF, 32'd3, "div_max_3");
        wait_result(1'b1, 1'b0);
        issue(3'd7, 32'd5, 32'd9, "div_small");
        wait_result(1'b0, 1'b0);

        // Each next op is issued in the done cycle of the previous one.
        issue(3'd6, 32'd7, 32'd6, "b2b_mul");
        wait_result(1'b0, 1'b0);
        issue(3'd7, 32'd1000, 32'd33, "b2b_div");
        wait_result(1'b0, 1'b0);
        issue(3'd0, 32'd40, 32'd2, "b2b_add");
        wait_result(1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            issue(3'(i), $urandom, $urandom_range(0, 255), $sformatf("rnd%0d", i));
            wait_result(1'b0, 1'b0);
        end

        // Abort a MULU at its tenth busy cycle; the previous nonzero result must clear.
        issue(3'd0, 32'h8000_0000, 32'd5, "pre_abort");
        wait_result(1'b0, 1'b0);
        issue(3'd6, 32'h0000_1234, 32'h0000_5678, "mul_aborted");
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check("abort.busy_before", {63'd0, bus.busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("abort.w",    {32'd0, bus.w},    64'd0);
        check("abort.hi",   {32'd0, bus.hi},   64'd0);
        check("abort.busy", {63'd0, bus.busy}, 64'd0);
        check("abort.done", {63'd0, bus.done}, 64'd0);
        check("abort.zero", {63'd0, bus.zero}, 64'd1);
        check("abort.neg",  {63'd0, bus.neg},  64'd0);
        void'(exp_q.pop_back());
        rst = 1'b0;
        issue(3'd0, 32'd2, 32'd2, "add_after_abort");
        wait_result(1'b0, 1'b0);
        quiet("after_abort", 40);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
